// File: rtl/subtrator_serial_ctrl_pkg.sv
// Shared definitions for the serial subtractor family: FSM encodings and default width.
package subtrator_serial_ctrl_pkg;
  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit-counter width able to hold the value WIDTH itself.
  function automatic int cnt_bits(input int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/subtrator_serial_ctrl_if.sv
// Request/result bundle of the serial subtractor; master issues operands, slave returns A-B.
interface subtrator_serial_ctrl_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             zero;

  modport master (
    output start, a, b,
    input  ready, busy, done, diff, borrow_out, zero
  );

  modport slave (
    input  start, a, b,
    output ready, busy, done, diff, borrow_out, zero
  );
endinterface

// File: rtl/meio_subtrator.sv
// Half subtractor: d = x - y, bo set when y > x.
module meio_subtrator (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);
  assign d  = x ^ y;
  assign bo = ~x & y;
endmodule

// File: rtl/subtrator_completo.sv
// One-bit full subtractor built from two half subtractors and an OR of their borrows.
module subtrator_completo (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic d1, b1, b2;

  meio_subtrator u_h1 (.x(a),  .y(b),   .d(d1), .bo(b1));
  meio_subtrator u_h2 (.x(d1), .y(bin), .d(d),  .bo(b2));

  assign bout = b1 | b2;
endmodule

// File: rtl/subtrator_serial_ctrl.sv
// Bit-serial A-B: one bit per RUN cycle LSB-first, result published only when the last bit lands.
module subtrator_serial_ctrl
  import subtrator_serial_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic                    clk,
  input logic                    rst_n,
  subtrator_serial_ctrl_if.slave bus
);
  localparam int              CNT_W = cnt_bits(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nxt;
  logic [WIDTH-1:0] diff_q;
  logic [CNT_W-1:0] cnt;
  logic             bor, bor_nxt, d_bit;
  logic             borrow_q, zero_q;
  logic             accept, last;

  assign accept = (state == IDLE) && bus.start;
  assign last   = (state == RUN) && (cnt == LAST);

  subtrator_completo u_cell (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .bin (bor),
    .d   (d_bit),
    .bout(bor_nxt)
  );

  assign res_nxt = {d_bit, res_sr[WIDTH-1:1]};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // The partial result lives only in res_sr; diff_q is the architectural output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      bor      <= 1'b0;
      cnt      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
    end else if (accept) begin
      a_sr   <= bus.a;
      b_sr   <= bus.b;
      res_sr <= '0;
      bor    <= 1'b0;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_nxt;
      bor    <= bor_nxt;
      cnt    <= cnt + ONE;
      if (last) begin
        diff_q   <= res_nxt;
        borrow_q <= bor_nxt;
        zero_q   <= (res_nxt == '0) && !bor_nxt;
      end
    end
  end

  assign bus.ready      = (state == IDLE);
  assign bus.busy       = (state == RUN);
  assign bus.done       = (state == DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;
  assign bus.zero       = zero_q;
endmodule

// File: doc/subtrator_serial_ctrl.md
SUBTRATOR_SERIAL_CTRL -- requirements
Module: subtrator_serial_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, request to begin one subtraction A-B.
REQ-005 SHALL have port a, input, WIDTH, minuend, sampled only on an accepted start.
REQ-006 SHALL have port b, input, WIDTH, subtrahend, sampled only on an accepted start.
REQ-007 SHALL have port ready, output, 1, high only in state IDLE.
REQ-008 SHALL have port busy, output, 1, high only in state RUN.
REQ-009 SHALL have port done, output, 1, one-cycle completion pulse, high only in state DONE.
REQ-010 SHALL have port diff, output, WIDTH, result A-B modulo 2^WIDTH.
REQ-011 SHALL have port borrow_out, output, 1, final borrow, high when A<B unsigned.
REQ-012 SHALL have port zero, output, 1, high when diff is all zeros and borrow_out is 0.

Function
REQ-013 SHALL implement FSM with states IDLE, RUN and DONE, and no other reachable state.
REQ-014 SHALL accept start only in IDLE: it SHALL load a and b into shift registers, clear the borrow flop and the bit counter, and go to RUN.
REQ-015 SHALL ignore start in RUN and DONE, with no effect on operands, counter or outputs.
REQ-016 SHALL in each RUN cycle process one bit LSB-first: d = a0^b0^bor; bor_next = (~a0&b0)|(~(a0^b0)&bor).
REQ-017 SHALL shift d into the result register at the MSB and shift both operand registers right by one bit in each RUN cycle.
REQ-018 SHALL stay in RUN for exactly WIDTH cycles, then go to DONE.
REQ-019 SHALL assert done for exactly one cycle, starting WIDTH clock edges after the edge that sampled start (WIDTH=8: start sampled at edge 0, done high between edges 8 and 9).
REQ-020 SHALL go from DONE to IDLE unconditionally on the next edge; a start held high SHALL be accepted in the following IDLE cycle (minimum WIDTH+2 cycles between accepted starts).
REQ-021 SHALL update diff, borrow_out and zero only on the RUN->DONE transition, and hold them until the next RUN->DONE transition.
REQ-022 SHALL keep the internal partial result invisible on diff while in RUN.
REQ-023 SHALL make the bit counter exactly clog2(WIDTH+1) bits wide, with no wrap-around before it reaches WIDTH.
REQ-024 SHALL have no combinational path from a, b or start to any output.

Reset
REQ-025 SHALL, while rst_n=0, force state IDLE; diff=0, borrow_out=0, zero=0, done=0, busy=0, ready=1; counter, borrow flop and operand registers=0.
REQ-026 SHALL abort an operation when reset is asserted during RUN, with no done pulse and no partial result visible afterwards.
REQ-027 SHALL accept start on the first rising edge after rst_n deasserts.

Structure
REQ-028 SHALL take the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the WIDTH default from a shared include file used by the subtractor family.
REQ-029 SHALL build the one-bit full-subtraction cell as sub-module subtrator_completo, made of two meio_subtrator instances plus an OR of their borrows.
REQ-030 SHALL keep the FSM, counter and shift registers in subtrator_serial_ctrl itself.

Verification
REQ-031 SHALL cover: a=0x05, b=0x03, start -> done after 8 edges, diff=0x02, borrow_out=0, zero=0.
REQ-032 SHALL cover: a=0x03, b=0x05 -> diff=0xFE, borrow_out=1, zero=0.
REQ-033 SHALL cover: a=0x00, b=0x00 -> diff=0x00, borrow_out=0, zero=1; then a=0x00, b=0x01 -> diff=0xFF, borrow_out=1.
REQ-034 SHALL cover: start re-pulsed with a=0xAA during RUN -> ignored; result of the original operands returned, done pulses once.
REQ-035 SHALL cover: rst_n low at 4th RUN cycle -> immediately IDLE, ready=1, diff=0, no done; a new start completes normally.
REQ-036 SHALL cover: start held high continuously for 3 operations -> done pulses spaced exactly 10 cycles apart, each result correct.
